// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
// master = fetch/execute pipeline, slave = predictor.
interface branch_predictor_if;
  logic        if_vld;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        alu_branch;
  logic        alu_call;
  logic        alu_return;
  logic        alu_taken;
  logic        alu_flush;
  logic [31:0] alu_target;
  logic [31:0] alu_pc;
  logic        bp_vld;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic [31:0] bp_pc;
  logic        fetch_redirect;
  logic [31:0] fetch_redirect_pc;
  logic [15:0] bp_miss_cnt;

  modport master (
    output if_vld, if_pc, if_stall,
    output alu_branch, alu_call, alu_return, alu_taken, alu_flush, alu_target, alu_pc,
    input  bp_vld, bp_taken, bp_target, bp_pc,
    input  fetch_redirect, fetch_redirect_pc, bp_miss_cnt
  );

  modport slave (
    input  if_vld, if_pc, if_stall,
    input  alu_branch, alu_call, alu_return, alu_taken, alu_flush, alu_target, alu_pc,
    output bp_vld, bp_taken, bp_target, bp_pc,
    output fetch_redirect, fetch_redirect_pc, bp_miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters plus a circular return-address stack.
// One-cycle registered prediction; execute-stage resolution trains the tables.
module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4
) (
  input logic               CLK,
  input logic               RSTN,
  branch_predictor_if.slave bp
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);

  localparam logic [1:0] T_BR   = 2'd0;
  localparam logic [1:0] T_JMP  = 2'd1;
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  // BTB storage
  logic [ENTRIES-1:0]         btb_v;
  logic [ENTRIES-1:0][TW-1:0] btb_tag;
  logic [ENTRIES-1:0][31:0]   btb_tgt;
  logic [ENTRIES-1:0][1:0]    btb_cnt;
  logic [ENTRIES-1:0][1:0]    btb_typ;

  // RAS storage: ras_tp is the next free slot, so the top lives at ras_tp-1
  logic [RAS_DEPTH-1:0][31:0] ras;
  logic [RW-1:0]              ras_tp;
  logic [RW-1:0]              ras_top_idx;
  logic [RW:0]                ras_cnt;
  logic                       ras_empty;
  logic [31:0]                ras_top;

  // lookup path
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] rd_tag;
  logic          rd_hit;
  logic          pred_taken;
  logic [31:0]   pred_tgt;

  // update path
  logic [IW-1:0] wr_idx;
  logic [TW-1:0] wr_tag;
  logic          wr_hit;
  logic [1:0]    new_cnt;
  logic [1:0]    new_typ;
  logic [31:0]   link_pc;

  // registered prediction
  logic        bp_vld_q;
  logic        bp_taken_q;
  logic [31:0] bp_target_q;
  logic [31:0] bp_pc_q;
  logic [15:0] miss_cnt_q;

  logic unused_ok;
  assign unused_ok = ^{bp.if_pc[1:0], bp.alu_pc[1:0]};

  assign ras_top_idx = ras_tp - 1'b1;
  assign ras_empty   = (ras_cnt == '0);
  assign ras_top     = ras[ras_top_idx];

  assign rd_idx = bp.if_pc[IW+1:2];
  assign rd_tag = bp.if_pc[31:IW+2];
  assign rd_hit = btb_v[rd_idx] && (btb_tag[rd_idx] == rd_tag);

  always_comb begin
    pred_taken = rd_hit && ((btb_typ[rd_idx] != T_BR) || btb_cnt[rd_idx][1]);
    pred_tgt   = bp.if_pc + 32'd4;
    if (rd_hit) begin
      if ((btb_typ[rd_idx] == T_RET) && !ras_empty) pred_tgt = ras_top;
      else                                          pred_tgt = btb_tgt[rd_idx];
    end
  end

  assign wr_idx  = bp.alu_pc[IW+1:2];
  assign wr_tag  = bp.alu_pc[31:IW+2];
  assign wr_hit  = btb_v[wr_idx] && (btb_tag[wr_idx] == wr_tag);
  assign link_pc = bp.alu_pc + 32'd4;

  always_comb begin
    new_cnt = bp.alu_taken ? 2'd2 : 2'd1;
    if (wr_hit) begin
      if (bp.alu_taken) new_cnt = (btb_cnt[wr_idx] == 2'd3) ? 2'd3 : btb_cnt[wr_idx] + 2'd1;
      else              new_cnt = (btb_cnt[wr_idx] == 2'd0) ? 2'd0 : btb_cnt[wr_idx] - 2'd1;
    end
    // an already-saturated or already-JMP taken branch is promoted to unconditional
    if (bp.alu_return)    new_typ = T_RET;
    else if (bp.alu_call) new_typ = T_CALL;
    else if (bp.alu_taken && wr_hit &&
             ((btb_cnt[wr_idx] == 2'd3) || (btb_typ[wr_idx] == T_JMP)))
                          new_typ = T_JMP;
    else                  new_typ = T_BR;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      btb_v   <= '0;
      btb_cnt <= '0;
    end else if (bp.alu_branch) begin
      btb_v[wr_idx]   <= 1'b1;
      btb_cnt[wr_idx] <= new_cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && bp.alu_branch) begin
      btb_tag[wr_idx] <= wr_tag;
      btb_tgt[wr_idx] <= bp.alu_target;
      btb_typ[wr_idx] <= new_typ;
    end
  end

  // circular stack: pushing when full simply wraps over the oldest slot
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ras_cnt <= '0;
      ras_tp  <= '0;
    end else begin
      case ({bp.alu_call, bp.alu_return})
        2'b10: begin
          ras[ras_tp] <= link_pc;
          ras_tp      <= ras_tp + 1'b1;
          if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
        end
        2'b01: begin
          if (!ras_empty) begin
            ras_tp  <= ras_top_idx;
            ras_cnt <= ras_cnt - 1'b1;
          end
        end
        2'b11: begin
          if (ras_empty) begin
            ras[ras_tp] <= link_pc;
            ras_tp      <= ras_tp + 1'b1;
            ras_cnt     <= ras_cnt + 1'b1;
          end else begin
            ras[ras_top_idx] <= link_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      bp_vld_q    <= 1'b0;
      bp_taken_q  <= 1'b0;
      bp_target_q <= '0;
      bp_pc_q     <= '0;
    end else begin
      if (!bp.if_stall) begin
        bp_vld_q    <= bp.if_vld;
        bp_pc_q     <= bp.if_pc;
        bp_taken_q  <= pred_taken;
        bp_target_q <= pred_tgt;
      end
      // flush kills the in-flight prediction even while fetch is frozen
      if (bp.alu_flush) begin
        bp_vld_q   <= 1'b0;
        bp_taken_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN)                                   miss_cnt_q <= '0;
    else if (bp.alu_flush && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 16'd1;
  end

  assign bp.bp_vld            = bp_vld_q;
  assign bp.bp_taken          = bp_taken_q;
  assign bp.bp_target         = bp_target_q;
  assign bp.bp_pc             = bp_pc_q;
  assign bp.bp_miss_cnt       = miss_cnt_q;
  assign bp.fetch_redirect    = bp.alu_flush;
  assign bp.fetch_redirect_pc = bp.alu_taken ? bp.alu_target : link_pc;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor: lookup expectations are queued at
// drive time and checked one cycle later; flush/stall/reset checked inline.
module tb_branch_predictor;
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  branch_predictor_if bpi();

  branch_predictor #(.ENTRIES(16), .RAS_DEPTH(4)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bp   (bpi)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  exp_t tbl[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] exp_miss = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // each queued lookup must appear on bp_* right after the next rising edge
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("bp_vld",    32'(bpi.bp_vld),   32'd1);
      chk("bp_pc",     bpi.bp_pc,         e.pc);
      chk("bp_taken",  32'(bpi.bp_taken), 32'(e.taken));
      chk("bp_target", bpi.bp_target,     e.tgt);
    end
  end

  task automatic clr();
    bpi.if_vld     = 1'b0;
    bpi.if_pc      = '0;
    bpi.if_stall   = 1'b0;
    bpi.alu_branch = 1'b0;
    bpi.alu_call   = 1'b0;
    bpi.alu_return = 1'b0;
    bpi.alu_taken  = 1'b0;
    bpi.alu_flush  = 1'b0;
    bpi.alu_target = '0;
    bpi.alu_pc     = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    clr();
  endtask

  task automatic look(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    bpi.if_vld = 1'b1;
    bpi.if_pc  = pc;
    sb.push_back('{pc, t, tgt});
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic call, input logic ret, input logic br);
    bpi.alu_pc     = pc;
    bpi.alu_taken  = t;
    bpi.alu_target = tgt;
    bpi.alu_call   = call;
    bpi.alu_return = ret;
    bpi.alu_branch = br;
  endtask

  task automatic chk_idle_out(input string tag, input logic [15:0] miss);
    chk({tag, "_vld"},    32'(bpi.bp_vld),   32'd0);
    chk({tag, "_taken"},  32'(bpi.bp_taken), 32'd0);
    chk({tag, "_target"}, bpi.bp_target,     32'd0);
    chk({tag, "_pc"},     bpi.bp_pc,         32'd0);
    chk({tag, "_miss"},   32'(bpi.bp_miss_cnt), 32'(miss));
  endtask

  initial begin
    tbl = '{
      '{32'h0000_0100, 1'b1, 32'h0000_0200},  // trained taken
      '{32'h0000_0140, 1'b0, 32'h0000_0144},  // alias of 0x100 index, tag differs
      '{32'h0000_0108, 1'b0, 32'h0000_0800},  // trained not-taken, hit keeps target
      '{32'h0000_0104, 1'b0, 32'h0000_0108},  // never trained
      '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000},  // fall-through wraps
      '{32'h0000_0500, 1'b0, 32'h0000_0504}
    };
    clr();
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    chk_idle_out("rst", 16'd0);
    RSTN = 1'b1;

    // cold lookup
    look(32'h100, 1'b0, 32'h104); tick();

    // train, then table of lookups
    upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1); tick();
    upd(32'h108, 1'b0, 32'h800, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 6; i++) begin
      look(tbl[i].pc, tbl[i].taken, tbl[i].tgt);
      tick();
    end

    // same-cycle lookup sees pre-update state; two not-taken updates flip direction
    look(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h200, 1'b0, 1'b0, 1'b1); tick();
    upd(32'h100, 1'b0, 32'h200, 1'b0, 1'b0, 1'b1); tick();
    look(32'h100, 1'b0, 32'h200); tick();

    // stall holds outputs
    look(32'h108, 1'b0, 32'h800); tick();
    bpi.if_stall = 1'b1; bpi.if_vld = 1'b1; bpi.if_pc = 32'h100;
    tick();
    chk("stall_vld", 32'(bpi.bp_vld), 32'd1);
    chk("stall_pc",  bpi.bp_pc,       32'h108);
    chk("stall_tgt", bpi.bp_target,   32'h800);

    // flush while stalled, not taken
    bpi.if_stall = 1'b1; bpi.alu_flush = 1'b1; bpi.alu_taken = 1'b0;
    bpi.alu_pc = 32'h500; bpi.alu_target = 32'h9999;
    #1;
    chk("redir",    32'(bpi.fetch_redirect), 32'd1);
    chk("redir_pc", bpi.fetch_redirect_pc,   32'h504);
    tick(); exp_miss++;
    chk("flush_vld",   32'(bpi.bp_vld),      32'd0);
    chk("flush_taken", 32'(bpi.bp_taken),    32'd0);
    chk("flush_miss",  32'(bpi.bp_miss_cnt), 32'(exp_miss));
    chk("no_redir",    32'(bpi.fetch_redirect), 32'd0);

    // flush taken, then flush with wrapping fall-through
    bpi.alu_flush = 1'b1; bpi.alu_taken = 1'b1; bpi.alu_target = 32'h1234_5678; bpi.alu_pc = 32'h40;
    #1; chk("redir_tk", bpi.fetch_redirect_pc, 32'h1234_5678);
    tick(); exp_miss++;
    bpi.alu_flush = 1'b1; bpi.alu_taken = 1'b0; bpi.alu_pc = 32'hFFFF_FFFC;
    #1; chk("redir_wrap", bpi.fetch_redirect_pc, 32'h0);
    tick(); exp_miss++;
    chk("miss3", 32'(bpi.bp_miss_cnt), 32'(exp_miss));

    // RAS: return entry at 0x400, call at 0x300 pushes 0x304
    upd(32'h400, 1'b1, 32'h480, 1'b0, 1'b1, 1'b1); tick();
    upd(32'h300, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0); tick();
    look(32'h400, 1'b1, 32'h304); tick();
    upd(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    look(32'h400, 1'b1, 32'h480); tick();

    // five pushes into depth 4, then LIFO pops; lookup sees pre-pop top
    for (int k = 0; k < 5; k++) begin
      upd(32'h1000 + 32'(k * 16), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    end
    for (int k = 0; k < 4; k++) begin
      look(32'h400, 1'b1, 32'h1044 - 32'(k * 16));
      upd(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    end
    look(32'h400, 1'b1, 32'h480);
    upd(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    upd(32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    look(32'h400, 1'b1, 32'h2004);
    upd(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    look(32'h400, 1'b1, 32'h480); tick();

    // call+return together: push when empty, replace top otherwise
    upd(32'h600, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0); tick();
    look(32'h400, 1'b1, 32'h604); tick();
    upd(32'h700, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0); tick();
    look(32'h400, 1'b1, 32'h704);
    upd(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    look(32'h400, 1'b1, 32'h480); tick();

    // reset in the middle of an update + flush
    upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1); tick();
    look(32'h100, 1'b1, 32'h200); tick();
    RSTN = 1'b0;
    bpi.if_vld = 1'b1; bpi.if_pc = 32'h108;
    upd(32'h104, 1'b1, 32'hABCD_0000, 1'b0, 1'b0, 1'b1);
    bpi.alu_flush = 1'b1;
    #1;
    chk("rst_redir",    32'(bpi.fetch_redirect), 32'd1);
    chk("rst_redir_pc", bpi.fetch_redirect_pc,   32'hABCD_0000);
    tick();
    exp_miss = 16'd0;
    chk_idle_out("midrst", exp_miss);
    RSTN = 1'b1;
    look(32'h100, 1'b0, 32'h104); tick();
    look(32'h104, 1'b0, 32'h108); tick();

    @(negedge CLK);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
